// File: rtl/instr_mem_loader.sv
// Byte-stream loader that assembles big-endian 32-bit words and writes them to instruction memory.
// Optional trailing XOR checksum word enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_WORDS  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CKSUM,
`endif
    S_DONE
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CKSUM;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(NUM_WORDS);

  state_t                state, next;
  logic [ADDR_WIDTH:0]   len, len_clamp;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            idx;
  logic [31:0]           word;
  logic                  rx, start_ok, last_word;

  assign rx        = byte_valid & byte_ready;
  assign start_ok  = start & ((state == S_IDLE) | (state == S_DONE));
  assign last_word = ({1'b0, addr} == len - 1'b1);
  assign len_clamp = (load_len > MAX_LEN) ? MAX_LEN : load_len;
  assign mem_addr  = addr;
  assign mem_wdata = word;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else       state <= next;

  always_comb begin
    next = state;
    case (state)
      S_IDLE, S_DONE:
        if (start) next = (len_clamp == '0) ? S_FINAL : S_RECV;
      S_RECV:
        if (rx && idx == 2'd3) next = S_WRITE;
      S_WRITE:
        next = last_word ? S_FINAL : S_RECV;
`ifdef LOADER_CHECKSUM_EN
      S_CKSUM:
        if (rx && idx == 2'd3) next = S_DONE;
`endif
      default: next = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_RECV:  begin byte_ready = 1'b1; busy = 1'b1; end
      S_WRITE: begin mem_we = 1'b1; busy = 1'b1; end
`ifdef LOADER_CHECKSUM_EN
      S_CKSUM: begin byte_ready = 1'b1; busy = 1'b1; end
`endif
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Bytes shift in from the bottom so the first byte ends up in [31:24].
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      len          <= '0;
      addr         <= '0;
      idx          <= '0;
      word         <= '0;
      words_loaded <= '0;
    end else begin
      if (start_ok) begin
        len          <= len_clamp;
        addr         <= '0;
        idx          <= '0;
        words_loaded <= '0;
      end
      if (rx) begin
        word <= {word[23:0], byte_in};
        idx  <= idx + 2'd1;
      end
      if (state == S_WRITE) begin
        words_loaded <= words_loaded + 1'b1;
        if (!last_word) addr <= addr + 1'b1;
      end
    end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] acc;
  logic        err_q;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc   <= '0;
      err_q <= 1'b0;
    end else begin
      if (start_ok) begin
        acc   <= '0;
        err_q <= 1'b0;
      end
      if (state == S_WRITE) acc <= acc ^ word;
      if (state == S_CKSUM && rx && idx == 2'd3)
        err_q <= ({word[23:0], byte_in} != acc);
    end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: write log, cycle timing, clamping, reset abort, checksum.
module tb_instr_mem_loader;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset, start, byte_valid;
  logic [AW:0]   load_len;
  logic [7:0]    byte_in;
  logic          byte_ready, mem_we, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   words_loaded;

  instr_mem_loader #(.ADDR_WIDTH(AW), .NUM_WORDS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .words_loaded(words_loaded), .error(error)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  int cyc = 0;
  int nwr = 0, nbad = 0;
  int          wr_cyc [256];
  logic [31:0] wr_data[256];
  logic [AW-1:0] wr_addr[256];

  always @(posedge clk) cyc <= cyc + 1;

  // Write log sampled mid-cycle; also flags any overlap of ready and write.
  always @(negedge clk) begin
    if (mem_we && nwr < 256) begin
      wr_cyc[nwr]  = cyc;
      wr_data[nwr] = mem_wdata;
      wr_addr[nwr] = mem_addr;
      nwr = nwr + 1;
    end
    if (mem_we && byte_ready) nbad = nbad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_start(input int len, output int s);
    @(posedge clk); #1;
    start = 1'b1; load_len = (AW+1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
    s = cyc;
  endtask

  task automatic send(input logic [7:0] b[$], input bit gap);
    bit acc;
    int t;
    foreach (b[i]) begin
      byte_in = b[i]; byte_valid = 1'b1;
      t = 0;
      do begin
        @(negedge clk); acc = byte_ready;
        @(posedge clk); #1;
        t++;
      end while (!acc && t < 40);
      if (!acc) begin
        chk("byte_timeout", 0, 1);
        byte_valid = 1'b0;
        return;
      end
      if (gap) begin
        byte_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(output int c);
    int t = 0;
    c = -1;
    while (t < 400) begin
      @(negedge clk);
      if (done) begin c = cyc; return; end
      t++;
    end
    chk("done_timeout", 0, 1);
  endtask

  logic [7:0] s1[$];
  logic [7:0] q[$];
  logic [31:0] w;
  int s, c, base, bad, acc_cnt;

  initial begin
    reset = 1'b1; start = 1'b0; load_len = '0; byte_in = '0; byte_valid = 1'b0;
    s1 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {28'd0, byte_ready, mem_we, busy, done}, 32'd0);
    chk("rst_addr_data", mem_wdata | 32'(mem_addr), 32'd0);
    chk("rst_wl_err", {26'd0, words_loaded} | 32'(error), 32'd0);
    #2 reset = 1'b0;

    // Continuous stream, two words
    base = nwr;
    do_start(2, s);
    chk("start_busy_ready", {30'd0, busy, byte_ready}, 32'd3);
    send(s1, 1'b0);
    wait_done(c);
    chk("s1_nwr", nwr - base, 2);
    chk("s1_w0", wr_data[base], 32'h20080005);
    chk("s1_a0", 32'(wr_addr[base]), 0);
    chk("s1_w1", wr_data[base+1], 32'h01095020);
    chk("s1_a1", 32'(wr_addr[base+1]), 1);
    chk("s1_t0", wr_cyc[base] - s, 4);
    chk("s1_t1", wr_cyc[base+1] - s, 9);
`ifdef LOADER_CHECKSUM_EN
    q = '{8'h21, 8'h01, 8'h50, 8'h25};
    send(q, 1'b0);
    wait_done(c);
    chk("ck_good_lat", c - s, 14);
    chk("ck_good_err", 32'(error), 0);
    chk("ck_good_nwr", nwr - base, 2);
`else
    chk("s1_done_lat", c - s, 10);
    chk("s1_err", 32'(error), 0);
`endif
    chk("s1_wl", 32'(words_loaded), 2);
    chk("s1_busy", 32'(busy), 0);

    // Same stream with gaps
    base = nwr;
    do_start(2, s);
    send(s1, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    q = '{8'h00, 8'h00, 8'h00, 8'h00};
    send(q, 1'b1);
`endif
    wait_done(c);
    chk("gap_nwr", nwr - base, 2);
    chk("gap_w0", wr_data[base], 32'h20080005);
    chk("gap_w1", wr_data[base+1], 32'h01095020);
    chk("gap_wl", 32'(words_loaded), 2);
    chk("ready_in_write", nbad, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("ck_bad_err", 32'(error), 1);
`endif

    // Zero length
    base = nwr;
    do_start(0, s);
`ifdef LOADER_CHECKSUM_EN
    q = '{8'h00, 8'h00, 8'h00, 8'h00};
    send(q, 1'b0);
    wait_done(c);
    chk("z_err", 32'(error), 0);
`else
    @(negedge clk);
    chk("z_done", {30'd0, done, busy}, 32'd2);
`endif
    chk("z_nwr", nwr - base, 0);
    chk("z_wl", 32'(words_loaded), 0);

    // Clamped length 40 -> 32 words
    q = {};
    for (int i = 0; i < 32; i++) begin
      w = {8'(i), 8'(i) ^ 8'h5A, ~8'(i), 8'(i + 3)};
      q.push_back(w[31:24]); q.push_back(w[23:16]);
      q.push_back(w[15:8]);  q.push_back(w[7:0]);
    end
    base = nwr;
    do_start(40, s);
    send(q, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [31:0] x = '0;
      logic [7:0] cq[$];
      for (int i = 0; i < 32; i++) x ^= {8'(i), 8'(i) ^ 8'h5A, ~8'(i), 8'(i + 3)};
      cq = '{x[31:24], x[23:16], x[15:8], x[7:0]};
      send(cq, 1'b0);
    end
`endif
    wait_done(c);
    chk("clamp_nwr", nwr - base, 32);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      w = {8'(i), 8'(i) ^ 8'h5A, ~8'(i), 8'(i + 3)};
      if (32'(wr_addr[base+i]) != i || wr_data[base+i] !== w) bad++;
    end
    chk("clamp_seq", bad, 0);
    chk("clamp_wl", 32'(words_loaded), 32);
    chk("clamp_err", 32'(error), 0);
    byte_in = 8'hEE; byte_valid = 1'b1;
    acc_cnt = 0;
    repeat (6) begin @(negedge clk); if (byte_ready) acc_cnt++; end
    byte_valid = 1'b0;
    chk("clamp_extra", acc_cnt + (nwr - base), 32);

    // Reset mid-load, after two bytes of the second word
    do_start(2, s);
    q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09};
    send(q, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("abort_outs", {28'd0, byte_ready, mem_we, busy, done}, 32'd0);
    chk("abort_addr_data", mem_wdata | 32'(mem_addr), 32'd0);
    chk("abort_wl_err", {26'd0, words_loaded} | 32'(error), 32'd0);
    @(posedge clk); #2 reset = 1'b0;
    base = nwr;
    do_start(1, s);
    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send(q, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    send(q, 1'b0);
`endif
    wait_done(c);
    chk("rl_nwr", nwr - base, 1);
    chk("rl_w0", wr_data[base], 32'hAABBCCDD);
    chk("rl_a0", 32'(wr_addr[base]), 0);
    chk("rl_wl", 32'(words_loaded), 1);
    chk("rl_err", 32'(error), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
